// File: rtl/spi_rx_word_unpacker.sv
// Captures a received SPI frame on frame_done and streams it out MSB-first as WORD_W words.
// Optional SPI_RX_UNPACK_SKID_EN adds a one-frame pending buffer so a back-to-back frame is not dropped.
module spi_rx_word_unpacker #(
    parameter int MAX_BITS = 1024,
    parameter int WORD_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_done,
    input  logic [MAX_BITS-1:0] frame_bits,
    input  logic [15:0]         frame_len,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WORD_W-1:0]   m_data,
    output logic [7:0]          m_nbits,
    output logic                m_last,
    output logic                busy,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic [15:0]         frame_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] buf_q, buf_d;
    logic [15:0]         rem_q, rem_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                m_valid_q, m_valid_d;
    logic [WORD_W-1:0]   m_data_q, m_data_d;
    logic [7:0]          m_nbits_q, m_nbits_d;
    logic                m_last_q, m_last_d;
    logic                busy_q, busy_d;
`ifdef SPI_RX_UNPACK_SKID_EN
    logic [MAX_BITS-1:0] pend_buf_q, pend_buf_d;
    logic [15:0]         pend_len_q, pend_len_d;
    logic                pend_vld_q, pend_vld_d;
`endif

    logic [15:0]         len_eff;
    logic [MAX_BITS-1:0] aligned;
    logic                new_frame;
    logic                hs;
    logic                last_word;
    logic [WORD_W-1:0]   top;

    // Left-align the frame so the first wire bit sits at the buffer MSB.
    always_comb begin
        len_eff   = (32'(frame_len) > MAX_BITS) ? 16'(MAX_BITS) : frame_len;
        aligned   = frame_bits << (MAX_BITS - int'(len_eff));
        new_frame = frame_done && (len_eff != 16'd0);
        hs        = m_valid_q && m_ready;
        last_word = rem_q <= 16'(WORD_W);
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;
`ifdef SPI_RX_UNPACK_SKID_EN
        pend_buf_d = pend_buf_q;
        pend_len_d = pend_len_q;
        pend_vld_d = pend_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (new_frame) begin
                    buf_d   = aligned;
                    rem_d   = len_eff;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs && last_word) begin
                    cnt_d = cnt_q + 16'd1;
`ifdef SPI_RX_UNPACK_SKID_EN
                    // Pending frame is older, so it goes first; the coincident one takes its slot.
                    if (pend_vld_q) begin
                        buf_d      = pend_buf_q;
                        rem_d      = pend_len_q;
                        pend_vld_d = new_frame;
                        if (new_frame) begin
                            pend_buf_d = aligned;
                            pend_len_d = len_eff;
                        end
                    end else if (new_frame) begin
                        buf_d = aligned;
                        rem_d = len_eff;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (new_frame) begin
                        buf_d = aligned;
                        rem_d = len_eff;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    if (hs) begin
                        buf_d = buf_q << WORD_W;
                        rem_d = rem_q - 16'(WORD_W);
                    end
                    if (new_frame) begin
`ifdef SPI_RX_UNPACK_SKID_EN
                        if (pend_vld_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            pend_buf_d = aligned;
                            pend_len_d = len_eff;
                            pend_vld_d = 1'b1;
                        end
`else
                        ovf_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word is formed from next-state so every output leaves a flop.
    always_comb begin
        top       = buf_d[MAX_BITS-1 -: WORD_W];
        m_valid_d = (state_d == EMIT);
        m_data_d  = '0;
        m_nbits_d = 8'd0;
        m_last_d  = 1'b0;
        if (state_d == EMIT) begin
            m_last_d = rem_d <= 16'(WORD_W);
            if (rem_d >= 16'(WORD_W)) begin
                m_data_d  = top;
                m_nbits_d = 8'(WORD_W);
            end else begin
                m_data_d  = top >> (WORD_W - int'(rem_d));
                m_nbits_d = 8'(rem_d);
            end
        end
`ifdef SPI_RX_UNPACK_SKID_EN
        busy_d = (state_d == EMIT) || pend_vld_d;
`else
        busy_d = (state_d == EMIT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            rem_q     <= 16'd0;
            cnt_q     <= 16'd0;
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_nbits_q <= 8'd0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SPI_RX_UNPACK_SKID_EN
            pend_buf_q <= '0;
            pend_len_q <= 16'd0;
            pend_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_nbits_q <= m_nbits_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
`ifdef SPI_RX_UNPACK_SKID_EN
            pend_buf_q <= pend_buf_d;
            pend_len_q <= pend_len_d;
            pend_vld_q <= pend_vld_d;
`endif
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_nbits     = m_nbits_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
    assign frame_count = cnt_q;

endmodule
